// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared playfield dimensions, cell/row types and the grid writer state enum
// used by tetris_grid_writer and anything that reads its grid.
// No ports (package).
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int GRID_W  = 10;
    localparam int GRID_H  = 18;
    localparam int COLOR_W = 3;
    localparam int CNT_W   = 5;

    typedef logic [COLOR_W-1:0]            color_t;
    typedef logic [GRID_W-1:0][COLOR_W-1:0] row_color_t;
    typedef logic [GRID_W-1:0]             row_occ_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } gw_state_t;

endpackage

// File: rtl/tetris_grid_writer.sv
// -----------------------------------------------------------------------------
// tetris_grid_writer
// Owns the playfield. Game logic writes single cells while idle. A lock_done
// pulse starts a bottom-up scan: every full row is removed by moving all rows
// above it down by one, and the number of removed rows is reported at the end.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   wr_valid/wr_ready   cell write handshake (ready only when idle)
//   wr_x, wr_y          target column / row (row 0 = top)
//   wr_color            colour of the written cell
//   lock_done           starts the full-row scan
//   grid, occ           per-cell colour and occupancy, indexed [row][col]
//   busy                scan / shift / report in progress
//   lines_valid         one-cycle pulse when the scan has finished
//   lines_cnt           rows cleared by the last scan, held until the next one
//   wr_err              one-cycle pulse for a dropped out-of-range write
//   topout              sticky flag: top row occupied after a scan
//
// Build option
//   GRID_TOPOUT_EN      when defined, topout is set if row 0 holds any cell at
//                       the end of a scan, and it blocks further writes until
//                       Reset. When undefined, topout is tied low.
// -----------------------------------------------------------------------------
module tetris_grid_writer
    import tetris_pkg::*;
#(
    parameter int COLS = GRID_W,
    parameter int ROWS = GRID_H,
    parameter int CW   = COLOR_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [3:0]               wr_x,
    input  logic [4:0]               wr_y,
    input  logic [CW-1:0]            wr_color,
    input  logic                     lock_done,
    output logic [COLS-1:0][CW-1:0]  grid [ROWS],
    output logic [COLS-1:0]          occ  [ROWS],
    output logic                     busy,
    output logic                     lines_valid,
    output logic [4:0]               lines_cnt,
    output logic                     wr_err,
    output logic                     topout
);

    localparam logic [3:0] X_LIMIT  = 4'(COLS);
    localparam logic [4:0] Y_LIMIT  = 5'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] CNT_MAX  = 5'd31;

    gw_state_t  state;
    logic [4:0] scan_row;
    logic [4:0] shift_row;
    logic [4:0] line_cnt;

    assign busy     = (state != IDLE);
    assign wr_ready = (state == IDLE) && !topout;

    // Main controller. A write and lock_done in the same idle cycle are both
    // taken: the cell lands on this edge, so the scan that starts on the next
    // cycle already sees it. After a row shift the scan resumes at the same
    // row, because that row now holds what used to be above it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ROWS; i++) begin
                occ[i]  <= '0;
                grid[i] <= '0;
            end
            state       <= IDLE;
            scan_row    <= '0;
            shift_row   <= '0;
            line_cnt    <= '0;
            lines_valid <= 1'b0;
            lines_cnt   <= '0;
            wr_err      <= 1'b0;
        end else begin
            lines_valid <= 1'b0;
            wr_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_valid && wr_ready) begin
                        if ((wr_x < X_LIMIT) && (wr_y < Y_LIMIT)) begin
                            occ[wr_y][wr_x]  <= 1'b1;
                            grid[wr_y][wr_x] <= wr_color;
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                    if (lock_done) begin
                        state    <= SCAN;
                        scan_row <= LAST_ROW;
                        line_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (&occ[scan_row]) begin
                        if (line_cnt != CNT_MAX) begin
                            line_cnt <= line_cnt + 5'd1;
                        end
                        shift_row <= scan_row;
                        state     <= SHIFT;
                    end else if (scan_row == 5'd0) begin
                        state <= DONE;
                    end else begin
                        scan_row <= scan_row - 5'd1;
                    end
                end
                SHIFT: begin
                    // Row 0 has nothing above it, so it is cleared rather than
                    // copied; that happens on the final shift step.
                    if (shift_row == 5'd0) begin
                        occ[0]  <= '0;
                        grid[0] <= '0;
                        state   <= SCAN;
                    end else begin
                        occ[shift_row]  <= occ[shift_row - 5'd1];
                        grid[shift_row] <= grid[shift_row - 5'd1];
                        if (shift_row == 5'd1) begin
                            occ[0]  <= '0;
                            grid[0] <= '0;
                            state   <= SCAN;
                        end
                        shift_row <= shift_row - 5'd1;
                    end
                end
                DONE: begin
                    lines_valid <= 1'b1;
                    lines_cnt   <= line_cnt;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GRID_TOPOUT_EN
    // Sticky top-out: any cell left in the top row once the scan is over.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            topout <= 1'b0;
        end else if ((state == DONE) && (|occ[0])) begin
            topout <= 1'b1;
        end
    end
`else
    assign topout = 1'b0;
`endif

endmodule
